sc_regshifter: RTL



---
 rtl/sc_regshifter.sv | 72 +++++++
 1 files changed

// File: rtl/sc_regshifter.sv
// Loadable left/right shift register feeding the BUSC write bus.
// Also returns active-low zero/negative flags and the last shifted-out bit to the controller.
module sc_regshifter #(
  parameter int DATAWIDTH_BUS                  = 8,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2
) (
  input  logic                                      SC_REGSHIFTER_CLOCK_50,
  input  logic                                      SC_REGSHIFTER_Reset_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]                  SC_REGSHIFTER_Data_In,
  input  logic                                      SC_REGSHIFTER_Load_InLow,
  input  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_REGSHIFTER_ShiftSelection_InLow,
  input  logic                                      SC_REGSHIFTER_SerialIn,
  output logic [DATAWIDTH_BUS-1:0]                  SC_REGSHIFTER_Data_Out,
  output logic                                      SC_REGSHIFTER_ShiftOut_Out,
  output logic                                      SC_REGSHIFTER_Zero_OutLow,
  output logic                                      SC_REGSHIFTER_Negative_OutLow
);

  localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_LEFT  =
    DATAWIDTH_REGSHIFTER_SELECTION'(1);
  localparam logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SEL_RIGHT =
    DATAWIDTH_REGSHIFTER_SELECTION'(2);

  logic [DATAWIDTH_BUS-1:0] data_q, data_d;
  logic                     shift_out_q, shift_out_d;
  logic                     zero_n_q, zero_n_d;
  logic                     neg_n_q, neg_n_d;

  always_comb begin
    data_d      = data_q;
    shift_out_d = shift_out_q;
    if (!SC_REGSHIFTER_Load_InLow) begin
      data_d = SC_REGSHIFTER_Data_In;
    end else begin
      // Unlisted (and undefined) selection codes fall to the hold default.
      case (SC_REGSHIFTER_ShiftSelection_InLow)
        SEL_LEFT: begin
          data_d      = {data_q[DATAWIDTH_BUS-2:0], SC_REGSHIFTER_SerialIn};
          shift_out_d = data_q[DATAWIDTH_BUS-1];
        end
        SEL_RIGHT: begin
          data_d      = {SC_REGSHIFTER_SerialIn, data_q[DATAWIDTH_BUS-1:1]};
          shift_out_d = data_q[0];
        end
        default: ;
      endcase
    end
    // Flags follow the next register value so they line up with Data_Out.
    zero_n_d = (data_d != '0);
    neg_n_d  = ~data_d[DATAWIDTH_BUS-1];
  end

  always_ff @(posedge SC_REGSHIFTER_CLOCK_50) begin
    if (SC_REGSHIFTER_Reset_InHigh) begin
      data_q      <= '0;
      shift_out_q <= 1'b0;
      zero_n_q    <= 1'b0;
      neg_n_q     <= 1'b1;
    end else begin
      data_q      <= data_d;
      shift_out_q <= shift_out_d;
      zero_n_q    <= zero_n_d;
      neg_n_q     <= neg_n_d;
    end
  end

  assign SC_REGSHIFTER_Data_Out        = data_q;
  assign SC_REGSHIFTER_ShiftOut_Out    = shift_out_q;
  assign SC_REGSHIFTER_Zero_OutLow     = zero_n_q;
  assign SC_REGSHIFTER_Negative_OutLow = neg_n_q;

endmodule
